// File: rtl/aes_req_sched.sv
`default_nettype none
// ============================================================================
// Module   : aes_req_sched
// Summary  : Shares one fully pipelined aes_128 core among NREQ requesters.
//            Issue is round-robin and credit-gated; results return in order
//            through an output FIFO. Defining AES_SCHED_FIXED_PRIO_EN
//            replaces round-robin with fixed lowest-index priority.
// Revision : 1.0
// ============================================================================
module aes_req_sched #(
    parameter int NREQ        = 4,
    parameter int TAG_W       = 4,
    parameter int CORE_LAT    = 21,
    parameter int OFIFO_DEPTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [128*NREQ-1:0]       req_state,
    input  logic [128*NREQ-1:0]       req_key,
    input  logic [TAG_W*NREQ-1:0]     req_tag,
    output logic [127:0]              core_state,
    output logic [127:0]              core_key,
    input  logic [127:0]              core_out,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [127:0]              rsp_data,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [TAG_W-1:0]          rsp_tag,
    output logic                      busy
);

    localparam int c_ID_W  = $clog2(NREQ);
    localparam int c_PTR_W = $clog2(OFIFO_DEPTH);
    localparam int c_CNT_W = $clog2(OFIFO_DEPTH + 1);
    localparam int c_ENT_W = 128 + c_ID_W + TAG_W;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(OFIFO_DEPTH);

    logic                          grant_found;
    logic [c_ID_W-1:0]             grant_idx;
    logic                          has_credit;
    logic                          accept;
    logic                          push;
    logic                          pop;

    logic [127:0]                  core_state_q, core_state_d;
    logic [127:0]                  core_key_q,   core_key_d;
    logic [CORE_LAT:0]             sh_vld_q,     sh_vld_d;
    logic [CORE_LAT:0][c_ID_W-1:0] sh_id_q,      sh_id_d;
    logic [CORE_LAT:0][TAG_W-1:0]  sh_tag_q,     sh_tag_d;
    logic [c_CNT_W-1:0]            inflight_q,   inflight_d;
    logic [c_CNT_W-1:0]            fifo_cnt_q,   fifo_cnt_d;
    logic [c_PTR_W-1:0]            wr_ptr_q,     wr_ptr_d;
    logic [c_PTR_W-1:0]            rd_ptr_q,     rd_ptr_d;
    logic [c_ENT_W-1:0]            fifo_mem_q [OFIFO_DEPTH];

    // Every accepted block already owns a FIFO slot, so the core can never be stalled.
    assign has_credit = ({1'b0, fifo_cnt_q} + {1'b0, inflight_q}) < {1'b0, c_FULL};
    assign accept     = grant_found & has_credit;

`ifdef AES_SCHED_FIXED_PRIO_EN
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[c_ID_W'(k)]) begin
                grant_found = 1'b1;
                grant_idx   = c_ID_W'(k);
            end
        end
    end
`else
    logic [c_ID_W-1:0] rr_ptr_q, rr_ptr_d;
    int                search_idx;

    // Scan backwards so the last hit is the first valid at/after the pointer.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        search_idx  = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            search_idx = int'(rr_ptr_q) + k;
            if (search_idx >= NREQ) search_idx = search_idx - NREQ;
            if (req_valid[c_ID_W'(search_idx)]) begin
                grant_found = 1'b1;
                grant_idx   = c_ID_W'(search_idx);
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (grant_idx == c_ID_W'(NREQ - 1)) ? '0 : grant_idx + c_ID_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rr_ptr_q <= '0;
        else      rr_ptr_q <= rr_ptr_d;
    end
`endif

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[grant_idx] = 1'b1;
    end

    assign push      = sh_vld_q[CORE_LAT];
    assign rsp_valid = (fifo_cnt_q != '0);
    assign pop       = rsp_valid & rsp_ready;

    // Shadow stage 0 sits beside the core input register; stage CORE_LAT lines up with core_out.
    always_comb begin
        core_state_d = core_state_q;
        core_key_d   = core_key_q;
        if (accept) begin
            core_state_d = req_state[int'(grant_idx)*128 +: 128];
            core_key_d   = req_key[int'(grant_idx)*128 +: 128];
        end
        sh_vld_d   = {sh_vld_q[CORE_LAT-1:0], accept};
        sh_id_d    = {sh_id_q[CORE_LAT-1:0], grant_idx};
        sh_tag_d   = {sh_tag_q[CORE_LAT-1:0], req_tag[int'(grant_idx)*TAG_W +: TAG_W]};
        inflight_d = inflight_q + c_CNT_W'(accept) - c_CNT_W'(push);
        fifo_cnt_d = fifo_cnt_q + c_CNT_W'(push) - c_CNT_W'(pop);
        wr_ptr_d   = wr_ptr_q + c_PTR_W'(push);
        rd_ptr_d   = rd_ptr_q + c_PTR_W'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_state_q <= '0;
            core_key_q   <= '0;
            sh_vld_q     <= '0;
            sh_id_q      <= '0;
            sh_tag_q     <= '0;
            inflight_q   <= '0;
            fifo_cnt_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            core_state_q <= core_state_d;
            core_key_q   <= core_key_d;
            sh_vld_q     <= sh_vld_d;
            sh_id_q      <= sh_id_d;
            sh_tag_q     <= sh_tag_d;
            inflight_q   <= inflight_d;
            fifo_cnt_q   <= fifo_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the read port is forced to zero while empty.
    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= {core_out, sh_id_q[CORE_LAT], sh_tag_q[CORE_LAT]};
    end

    assign {rsp_data, rsp_id, rsp_tag} = rsp_valid ? fifo_mem_q[rd_ptr_q] : '0;
    assign core_state = core_state_q;
    assign core_key   = core_key_q;
    assign busy       = (inflight_q != '0) | rsp_valid;

    a_no_fifo_overflow : assert property (@(posedge clk) disable iff (!rst)
        !(push && (fifo_cnt_q == c_FULL)));

endmodule
`default_nettype wire

// File: tb/tb_aes_req_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_req_sched
// Summary  : Directed and randomized bench for aes_req_sched with a stand-in
//            pipelined core and a queue-based reference of issue and return.
// Revision : 1.0
// ============================================================================
module tb_aes_req_sched;

    localparam int NREQ     = 4;
    localparam int TAG_W    = 4;
    localparam int CORE_LAT = 21;
    localparam int DEPTH    = 32;
    localparam int ID_W     = 2;

    localparam logic [127:0] KAT_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KAT_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic                    clk;
    logic                    rst;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [128*NREQ-1:0]     req_state;
    logic [128*NREQ-1:0]     req_key;
    logic [TAG_W*NREQ-1:0]   req_tag;
    logic [127:0]            core_state;
    logic [127:0]            core_key;
    logic [127:0]            core_out;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [127:0]            rsp_data;
    logic [ID_W-1:0]         rsp_id;
    logic [TAG_W-1:0]        rsp_tag;
    logic                    busy;

    aes_req_sched #(
        .NREQ(NREQ), .TAG_W(TAG_W), .CORE_LAT(CORE_LAT), .OFIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_state(req_state), .req_key(req_key), .req_tag(req_tag),
        .core_state(core_state), .core_key(core_key), .core_out(core_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_tag(rsp_tag),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in cipher: the known-answer vector maps to its real ciphertext.
    function automatic logic [127:0] core_f(input logic [127:0] s, input logic [127:0] k);
        if (s == KAT_PT && k == KAT_KEY) return KAT_CT;
        return {s[63:0] ^ k[127:64], s[127:64] + k[63:0]} ^ 128'h5a5a_c3c3_0ff0_9669_a5a5_3c3c_f00f_6996;
    endfunction

    // Core stand-in: never stalls and never resets, exactly CORE_LAT registers deep.
    logic [127:0] core_pipe [CORE_LAT];
    always @(posedge clk) begin
        core_pipe[0] <= core_f(core_state, core_key);
        for (int k = 1; k < CORE_LAT; k++) core_pipe[k] <= core_pipe[k-1];
    end
    assign core_out = core_pipe[CORE_LAT-1];

    typedef struct {
        logic [ID_W-1:0]  id;
        logic [TAG_W-1:0] tag;
        logic [127:0]     data;
        int               due;
    } exp_t;

    exp_t         sb[$];
    int           n_vec, n_err;
    int           cyc, mptr;
    int           n_acc, n_pop, n_rv;
    int           acc_by [NREQ];
    bit           seen_rsp;
    int           seen_cyc;
    logic [127:0] seen_data;
    logic [ID_W-1:0]  seen_id;
    logic [TAG_W-1:0] seen_tag;
    int           n0, p0, r0, acc_edge;

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic drive(input logic [NREQ-1:0] v, input logic rr);
        req_valid = v;
        rsp_ready = rr;
        for (int i = 0; i < NREQ; i++) begin
            req_state[128*i +: 128] = {$urandom, $urandom, $urandom, $urandom};
            req_key[128*i +: 128]   = {$urandom, $urandom, $urandom, $urandom};
            req_tag[TAG_W*i +: TAG_W] = TAG_W'($urandom);
        end
    endtask

    // Reference: an outstanding block (accepted, not popped) holds one credit;
    // each block becomes visible CORE_LAT+1 edges after its accepting edge.
    task automatic check_cycle();
        logic [NREQ-1:0] exp_rdy;
        logic            exp_v;
        exp_rdy = '0;
        if (sb.size() < DEPTH) begin
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (mptr + k) % NREQ;
                if (req_valid[j]) begin
                    exp_rdy[j] = 1'b1;
                    break;
                end
            end
        end
        chk("req_ready", 128'(req_ready), 128'(exp_rdy));
        chk("busy", 128'(busy), 128'(sb.size() != 0));
        exp_v = (sb.size() != 0) && (sb[0].due <= cyc);
        chk("rsp_valid", 128'(rsp_valid), 128'(exp_v));
        if (rsp_valid) begin
            n_rv++;
            if (!seen_rsp) begin
                seen_rsp  = 1'b1;
                seen_cyc  = cyc;
                seen_data = rsp_data;
                seen_id   = rsp_id;
                seen_tag  = rsp_tag;
            end
        end
        if (exp_v) begin
            chk("rsp_data", rsp_data, sb[0].data);
            chk("rsp_id", 128'(rsp_id), 128'(sb[0].id));
            chk("rsp_tag", 128'(rsp_tag), 128'(sb[0].tag));
            if (rsp_ready) begin
                void'(sb.pop_front());
                n_pop++;
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (exp_rdy[j]) begin
                exp_t e;
                e.id   = ID_W'(j);
                e.tag  = req_tag[TAG_W*j +: TAG_W];
                e.data = core_f(req_state[128*j +: 128], req_key[128*j +: 128]);
                e.due  = cyc + CORE_LAT + 2;
                sb.push_back(e);
                n_acc++;
                acc_by[j]++;
`ifndef AES_SCHED_FIXED_PRIO_EN
                mptr = (j + 1) % NREQ;
`endif
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0; mptr = 0;
        n_acc = 0; n_pop = 0; n_rv = 0; seen_rsp = 1'b0; seen_cyc = 0;
        for (int i = 0; i < NREQ; i++) acc_by[i] = 0;
        rst = 1'b0;
        drive('0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 128'(req_ready), 128'(0));
        chk("rst_core_state", core_state, 128'(0));
        chk("rst_core_key", core_key, 128'(0));
        chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("rst_rsp_data", rsp_data, 128'(0));
        chk("rst_rsp_id", 128'(rsp_id), 128'(0));
        chk("rst_rsp_tag", 128'(rsp_tag), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        rst = 1'b1;

        // Known-answer block from requester 1 and its latency
        drive(4'b0010, 1'b1);
        req_state[255:128] = KAT_PT;
        req_key[255:128]   = KAT_KEY;
        req_tag[7:4]       = 4'd5;
        cycle();
        acc_edge = cyc;
        chk("kat_core_state", core_state, KAT_PT);
        chk("kat_core_key", core_key, KAT_KEY);
        for (int i = 0; i < 40 && !seen_rsp; i++) begin
            drive('0, 1'b1);
            cycle();
        end
        chk("kat_seen", 128'(seen_rsp), 128'(1));
        chk("kat_latency", 128'(seen_cyc - acc_edge), 128'(CORE_LAT + 1));
        chk("kat_data", seen_data, KAT_CT);
        chk("kat_id", 128'(seen_id), 128'(1));
        chk("kat_tag", 128'(seen_tag), 128'(5));

        // All requesters valid, sink always ready: one issue every cycle
        n0 = n_acc;
        repeat (40) begin drive('1, 1'b1); cycle(); end
        chk("t2_accepts", 128'(n_acc - n0), 128'(40));
        repeat (CORE_LAT + 10) begin drive('0, 1'b1); cycle(); end

        // Randomized traffic with random back-pressure
        repeat (200) begin drive(NREQ'($urandom), ($urandom_range(0, 3) != 0)); cycle(); end
        repeat (CORE_LAT + 40) begin drive('0, 1'b1); cycle(); end

        // Back-pressure: credits cap issue at DEPTH, then everything drains in order
        n0 = n_acc;
        repeat (60) begin drive('1, 1'b0); cycle(); end
        chk("t3_accepts", 128'(n_acc - n0), 128'(DEPTH));
        chk("t3_ready_zero", 128'(req_ready), 128'(0));
        p0 = n_pop;
        repeat (60) begin drive('0, 1'b1); cycle(); end
        chk("t3_drained", 128'(n_pop - p0), 128'(DEPTH));
        repeat (5) begin drive('1, 1'b1); cycle(); end
        repeat (CORE_LAT + 10) begin drive('0, 1'b1); cycle(); end

        // Last credit: a pop in the same cycle as an accept does not add credit
        n0 = n_acc;
        repeat (DEPTH - 1) begin drive('1, 1'b0); cycle(); end
        repeat (CORE_LAT + 4) begin drive('0, 1'b0); cycle(); end
        drive('1, 1'b1); cycle();
        drive('1, 1'b0); cycle();
        chk("t5_ready_zero", 128'(req_ready), 128'(0));
        repeat (3) begin drive('1, 1'b0); cycle(); end
        chk("t5_accepts", 128'(n_acc - n0), 128'(DEPTH + 1));
        repeat (DEPTH + CORE_LAT + 10) begin drive('0, 1'b1); cycle(); end

        // Reset with 10 blocks in flight
        repeat (10) begin drive('1, 1'b1); cycle(); end
        drive('0, 1'b1);
        rst = 1'b0;
        #1;
        chk("t4_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("t4_busy", 128'(busy), 128'(0));
        sb.delete();
        mptr = 0;
        repeat (2) cycle();
        rst = 1'b1;
        r0 = n_rv;
        repeat (2 * CORE_LAT) begin drive('0, 1'b1); cycle(); end
        chk("t4_no_rsp", 128'(n_rv - r0), 128'(0));

`ifdef AES_SCHED_FIXED_PRIO_EN
        n0 = acc_by[0];
        p0 = acc_by[2];
        repeat (30) begin drive(4'b0101, 1'b1); cycle(); end
        chk("fp_req0_wins", 128'(acc_by[0] - n0), 128'(30));
        chk("fp_req2_never", 128'(acc_by[2] - p0), 128'(0));
        repeat (CORE_LAT + 10) begin drive('0, 1'b1); cycle(); end
`endif

        repeat (200) begin drive(NREQ'($urandom), ($urandom_range(0, 1) != 0)); cycle(); end
        repeat (DEPTH + CORE_LAT + 20) begin drive('0, 1'b1); cycle(); end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
